// File: rtl/gemm_pkg.sv
// gemm_pkg -- shared types and defaults for the GEMM operand loader slice.
//   loader_state_t : loader FSM states, LOAD_A -> LOAD_B -> LOAD_C -> START -> WAIT
//   DEF_*          : default operand width and matrix dimensions
//   idx_width()    : bit width of a row/column index for a given dimension
package gemm_pkg;

  localparam int unsigned DEF_DATA_WIDTH    = 64;
  localparam int unsigned DEF_MATRIX_WIDTH  = 4;
  localparam int unsigned DEF_MATRIX_HEIGHT = 4;

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    LOAD_C = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4
  } loader_state_t;

  // A dimension of 1 still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gemm_operand_loader_if.sv
// gemm_operand_loader_if -- bundle of the loader's stream and GEMM handshake.
//   valid/data/ready : element stream into the loader
//   gemm_done        : completion pulse from the GEMM stage
//   start/busy       : start pulse and busy flag toward the GEMM stage
// Modports: master drives the stream and gemm_done; slave is the loader side.
interface gemm_operand_loader_if
  import gemm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                         valid;
  logic signed [DATA_WIDTH-1:0] data;
  logic                         ready;
  logic                         gemm_done;
  logic                         start;
  logic                         busy;

  modport master (
    output valid, data, gemm_done,
    input  ready, start, busy
  );

  modport slave (
    input  valid, data, gemm_done,
    output ready, start, busy
  );
endinterface

// File: rtl/gemm_idx_counter.sv
// gemm_idx_counter -- row-major (row, col) walk over a MATRIX_HEIGHT x MATRIX_WIDTH matrix.
//   clk     : clock
//   advance : step to the next element (col first, then row)
//   clear   : synchronous return to (0,0), wins over advance
//   row/col : current element position
//   last    : current position is the bottom-right element
module gemm_idx_counter
  import gemm_pkg::*;
#(
  parameter int unsigned MATRIX_WIDTH  = DEF_MATRIX_WIDTH,
  parameter int unsigned MATRIX_HEIGHT = DEF_MATRIX_HEIGHT,
  localparam int unsigned ROW_W = idx_width(MATRIX_HEIGHT),
  localparam int unsigned COL_W = idx_width(MATRIX_WIDTH)
) (
  input  logic             clk,
  input  logic             advance,
  input  logic             clear,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MATRIX_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(MATRIX_WIDTH - 1);

  always_comb begin
    last = (row == ROW_LAST) && (col == COL_LAST);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end
endmodule

// File: rtl/gemm_operand_loader.sv
// gemm_operand_loader -- fills A, B and C operand matrices from an element stream,
// then kicks the GEMM stage and waits for it to finish.
//   iclk, irst            : clock, synchronous active-high reset
//   ivalid, idata, oready : element stream; transfer when ivalid && oready
//   igemm_done            : GEMM completion pulse, honoured only in WAIT
//   oa/ob/oc_matrix       : operand matrices, held through START and WAIT
//   ostart                : one-cycle start pulse (state START)
//   obusy                 : high in START and WAIT
//   oframe_count          : frames started, 16-bit wrapping
//                           (only with GEMM_LOADER_FRAMECNT_EN defined)
module gemm_operand_loader
  import gemm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned MATRIX_WIDTH  = DEF_MATRIX_WIDTH,
  parameter int unsigned MATRIX_HEIGHT = DEF_MATRIX_HEIGHT
) (
  input  logic                         iclk,
  input  logic                         irst,
  input  logic                         ivalid,
  input  logic signed [DATA_WIDTH-1:0] idata,
  output logic                         oready,
  input  logic                         igemm_done,
  output logic signed [DATA_WIDTH-1:0] oa_matrix [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1],
  output logic signed [DATA_WIDTH-1:0] ob_matrix [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1],
  output logic signed [DATA_WIDTH-1:0] oc_matrix [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1],
  output logic                         ostart,
  output logic                         obusy
`ifdef GEMM_LOADER_FRAMECNT_EN
  ,
  output logic [15:0]                  oframe_count
`endif
);
  localparam int unsigned ROW_W = idx_width(MATRIX_HEIGHT);
  localparam int unsigned COL_W = idx_width(MATRIX_WIDTH);

  loader_state_t    state;
  loader_state_t    state_next;
  logic             accept;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             last;

  always_comb begin
    oready = (state == LOAD_A) || (state == LOAD_B) || (state == LOAD_C);
    accept = ivalid && oready;
    ostart = (state == START);
    obusy  = (state == START) || (state == WAIT);
  end

  // The walk wraps to (0,0) by itself on the last element, so the only
  // explicit clear needed is reset.
  gemm_idx_counter #(
    .MATRIX_WIDTH (MATRIX_WIDTH),
    .MATRIX_HEIGHT(MATRIX_HEIGHT)
  ) u_idx (
    .clk    (iclk),
    .advance(accept),
    .clear  (irst),
    .row    (row),
    .col    (col),
    .last   (last)
  );

  always_comb begin
    state_next = state;
    case (state)
      LOAD_A:  if (accept && last) state_next = LOAD_B;
      LOAD_B:  if (accept && last) state_next = LOAD_C;
      LOAD_C:  if (accept && last) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (igemm_done) state_next = LOAD_A;
      default: state_next = LOAD_A;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state <= LOAD_A;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      for (int unsigned r = 0; r < MATRIX_HEIGHT; r++) begin
        for (int unsigned c = 0; c < MATRIX_WIDTH; c++) begin
          oa_matrix[r][c] <= '0;
          ob_matrix[r][c] <= '0;
          oc_matrix[r][c] <= '0;
        end
      end
    end else if (accept) begin
      case (state)
        LOAD_A:  oa_matrix[row][col] <= idata;
        LOAD_B:  ob_matrix[row][col] <= idata;
        LOAD_C:  oc_matrix[row][col] <= idata;
        default: ;
      endcase
    end
  end

`ifdef GEMM_LOADER_FRAMECNT_EN
  logic [15:0] frame_count_q;

  always_ff @(posedge iclk) begin
    if (irst) begin
      frame_count_q <= '0;
    end else if (state == START) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign oframe_count = frame_count_q;
`endif
endmodule

// File: tb/tb_gemm_operand_loader.sv
// tb_gemm_operand_loader -- directed self-checking bench for gemm_operand_loader
// at default parameters (64-bit elements, 4x4 matrices). Inputs change on the
// falling edge, outputs are checked on the falling edge after each rising edge.
// Frame-count checks are compiled in when GEMM_LOADER_FRAMECNT_EN is defined.
module tb_gemm_operand_loader;
  import gemm_pkg::*;

  logic iclk;
  logic irst;
  logic signed [63:0] a_mat [0:3][0:3];
  logic signed [63:0] b_mat [0:3][0:3];
  logic signed [63:0] c_mat [0:3][0:3];
`ifdef GEMM_LOADER_FRAMECNT_EN
  logic [15:0] frame_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  gemm_operand_loader_if #(.DATA_WIDTH(64)) bus ();

  gemm_operand_loader #(
    .DATA_WIDTH   (64),
    .MATRIX_WIDTH (4),
    .MATRIX_HEIGHT(4)
  ) dut (
    .iclk        (iclk),
    .irst        (irst),
    .ivalid      (bus.valid),
    .idata       (bus.data),
    .oready      (bus.ready),
    .igemm_done  (bus.gemm_done),
    .oa_matrix   (a_mat),
    .ob_matrix   (b_mat),
    .oc_matrix   (c_mat),
    .ostart      (bus.start),
    .obusy       (bus.busy)
`ifdef GEMM_LOADER_FRAMECNT_EN
    ,
    .oframe_count(frame_count)
`endif
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    @(negedge iclk);
  endtask

  // Frame with base b carries values b+1 .. b+48: A, then B, then C, row-major.
  task automatic check_frame(input string tag, input int base);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("%s A[%0d][%0d]", tag, r, c), a_mat[r][c], 64'(base + 1  + r*4 + c));
        check($sformatf("%s B[%0d][%0d]", tag, r, c), b_mat[r][c], 64'(base + 17 + r*4 + c));
        check($sformatf("%s C[%0d][%0d]", tag, r, c), c_mat[r][c], 64'(base + 33 + r*4 + c));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("%s A[%0d][%0d]", tag, r, c), a_mat[r][c], 64'd0);
        check($sformatf("%s B[%0d][%0d]", tag, r, c), b_mat[r][c], 64'd0);
        check($sformatf("%s C[%0d][%0d]", tag, r, c), c_mat[r][c], 64'd0);
      end
    end
  endtask

  // Sends a whole frame starting in LOAD_A; returns at the START cycle.
  // prev_b00 is what B[0][0] must still hold when the first B element is offered.
  task automatic send_frame(input int base, input bit gaps, input int prev_b00);
    for (int i = 1; i <= 48; i++) begin
      bus.valid = 1'b1;
      bus.data  = 64'(base + i);
      if (i == 17) check("old_b00_kept", b_mat[0][0], 64'(prev_b00));
      check("oready_load", bus.ready, 1'b1);
      check("ostart_load", bus.start, 1'b0);
      tick();
      if (gaps && i != 48) begin
        bus.valid = 1'b0;
        bus.data  = 64'hDEAD_BEEF_0BAD_F00D;
        check("ostart_gap", bus.start, 1'b0);
        tick();
      end
    end
    bus.valid = 1'b0;
    check("ostart_pulse", bus.start, 1'b1);
    check("obusy_start", bus.busy, 1'b1);
    check("oready_start", bus.ready, 1'b0);
  endtask

  // From START: one cycle into WAIT, then a done pulse back to LOAD_A.
  task automatic finish_frame();
    tick();
    check("ostart_wait", bus.start, 1'b0);
    check("obusy_wait", bus.busy, 1'b1);
    bus.gemm_done = 1'b1;
    tick();
    bus.gemm_done = 1'b0;
    check("oready_after_done", bus.ready, 1'b1);
    check("obusy_after_done", bus.busy, 1'b0);
  endtask

  initial begin
    irst          = 1'b1;
    bus.valid     = 1'b1;
    bus.data      = 64'd123;
    bus.gemm_done = 1'b1;
    @(negedge iclk);

    // Reset wins over a simultaneous transfer and done pulse.
    tick();
    check("rst_oready", bus.ready, 1'b1);
    check("rst_ostart", bus.start, 1'b0);
    check("rst_obusy", bus.busy, 1'b0);
    check_zero("rst");
`ifdef GEMM_LOADER_FRAMECNT_EN
    check("rst_frame_count", frame_count, 16'd0);
`endif
    irst          = 1'b0;
    bus.valid     = 1'b0;
    bus.gemm_done = 1'b0;
    check("oready_after_rst", bus.ready, 1'b1);

    // Back-to-back frame, values 1..48.
    send_frame(0, 1'b0, 0);
    check_frame("f1", 0);
    finish_frame();
    check("f1_kept_a00", a_mat[0][0], 64'd1);

    // Gapped frame with negative values -99..-52.
    send_frame(-100, 1'b1, 17);
    check_frame("f2", -100);

    // ivalid held high through START and WAIT; done pulse coincident with START.
    bus.valid     = 1'b1;
    bus.data      = 64'd999;
    bus.gemm_done = 1'b1;
    tick();
    bus.gemm_done = 1'b0;
    check("wait_after_start_done", bus.busy, 1'b1);
    check("wait_oready", bus.ready, 1'b0);
    check("wait_ostart", bus.start, 1'b0);
    tick();
    check("wait_still_busy", bus.busy, 1'b1);
    check("wait_still_not_ready", bus.ready, 1'b0);
    tick();
    check_frame("hold", -100);
    bus.gemm_done = 1'b1;
    tick();
    bus.gemm_done = 1'b0;
    check("resume_oready", bus.ready, 1'b1);
    check("resume_obusy", bus.busy, 1'b0);
    check("resume_a00_old", a_mat[0][0], -64'sd99);
    bus.data = 64'd777;
    tick();
    bus.valid = 1'b0;
    check("resume_a00_new", a_mat[0][0], 64'd777);
    check("resume_a01_old", a_mat[0][1], -64'sd98);

    // Transfers 2..20, then a done pulse in LOAD_B that must be ignored.
    for (int i = 2; i <= 20; i++) begin
      bus.valid = 1'b1;
      bus.data  = 64'(300 + i);
      tick();
    end
    bus.valid = 1'b0;
    check("partial_b03", b_mat[0][3], 64'd320);
    check("partial_b10_old", b_mat[1][0], -64'sd79);
    bus.gemm_done = 1'b1;
    tick();
    bus.gemm_done = 1'b0;
    check("loadb_done_oready", bus.ready, 1'b1);
    check("loadb_done_obusy", bus.busy, 1'b0);
    bus.valid = 1'b1;
    bus.data  = 64'd321;
    tick();
    bus.valid = 1'b0;
    check("loadb_continue_b10", b_mat[1][0], 64'd321);

    // Mid-frame reset with a competing transfer and done pulse.
    irst          = 1'b1;
    bus.valid     = 1'b1;
    bus.data      = 64'd555;
    bus.gemm_done = 1'b1;
    tick();
    irst          = 1'b0;
    bus.valid     = 1'b0;
    bus.gemm_done = 1'b0;
    check_zero("midrst");
    check("midrst_oready", bus.ready, 1'b1);
    check("midrst_obusy", bus.busy, 1'b0);
    check("midrst_ostart", bus.start, 1'b0);

    // Fresh frame after reset lands from A[0][0].
    send_frame(0, 1'b0, 0);
    check_frame("f3", 0);
    finish_frame();

`ifdef GEMM_LOADER_FRAMECNT_EN
    check("frame_count_1", frame_count, 16'd1);
    send_frame(1000, 1'b0, 17);
    finish_frame();
    send_frame(2000, 1'b1, 1017);
    finish_frame();
    check("frame_count_3", frame_count, 16'd3);
    force dut.frame_count_q = 16'hFFFF;
    tick();
    release dut.frame_count_q;
    check("frame_count_preset", frame_count, 16'hFFFF);
    send_frame(3000, 1'b0, 2017);
    finish_frame();
    check("frame_count_wrap", frame_count, 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/gemm_operand_loader.md
GEMM_OPERAND_LOADER -- requirements
Module: gemm_operand_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: operand element width in bits.
REQ-002 SHALL have parameter MATRIX_WIDTH, default 4: columns per matrix.
REQ-003 SHALL have parameter MATRIX_HEIGHT, default 4: rows per matrix.
REQ-004 SHALL have port iclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port irst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port ivalid, input, 1 bit: stream element present on idata.
REQ-007 SHALL have port idata, input, DATA_WIDTH bits, signed: stream element.
REQ-008 SHALL have port oready, output, 1 bit: loader accepts an element this cycle.
REQ-009 SHALL have port igemm_done, input, 1 bit: one-cycle completion pulse from the GEMM stage.
REQ-010 SHALL have ports oa_matrix, ob_matrix and oc_matrix, each an output, signed DATA_WIDTH, unpacked [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1]: operands for the GEMM stage.
REQ-011 SHALL have port ostart, output, 1 bit: one-cycle start pulse to the GEMM stage.
REQ-012 SHALL have port obusy, output, 1 bit: high in states START and WAIT.

Function
REQ-013 SHALL transfer an element only on a cycle with ivalid=1 and oready=1; ivalid=1 with oready=0 SHALL have no effect.
REQ-014 SHALL have states LOAD_A, LOAD_B, LOAD_C, START, WAIT, in that order, with WAIT returning to LOAD_A.
REQ-015 SHALL drive oready combinationally, high exactly in LOAD_A, LOAD_B and LOAD_C.
REQ-016 SHALL write the element accepted at (row, col) into the matrix selected by the state, in row-major order: col increments; at col=MATRIX_WIDTH-1, col wraps to 0 and row increments.
REQ-017 SHALL, on accepting the element at row=MATRIX_HEIGHT-1 and col=MATRIX_WIDTH-1, clear row and col and advance to the next state.
REQ-018 SHALL consume exactly 3*MATRIX_HEIGHT*MATRIX_WIDTH transfers per frame: 48 at default parameters.
REQ-019 SHALL assert ostart for exactly one cycle, the cycle immediately after the last C element is accepted, with state START; the next state is WAIT.
REQ-020 SHALL remain in WAIT until igemm_done=1, then enter LOAD_A on the following edge.
REQ-021 SHALL ignore igemm_done in every state except WAIT, including a pulse coincident with START.
REQ-022 SHALL hold oa_matrix, ob_matrix and oc_matrix unchanged in START and WAIT.
REQ-023 SHALL leave the previous frame's matrices in place until each element is overwritten by the new load.
REQ-024 SHALL not stall or drop data when ivalid toggles on any cycle pattern; gaps simply delay the frame.

Reset
REQ-025 SHALL, with irst=1 at a rising edge, enter LOAD_A, clear row and col to 0, and clear all matrix elements to 0, with ostart=0 and obusy=0.
REQ-026 SHALL drive oready=1 on the first cycle after reset is released.
REQ-027 SHALL give reset priority over any simultaneous transfer or igemm_done.
REQ-028 SHALL, on a mid-frame reset, discard the partial frame, and the next accepted element SHALL be A[0][0].

Configuration
REQ-029 SHALL, with macro GEMM_LOADER_FRAMECNT_EN defined, add output oframe_count, 16 bits: reset to 0 and incremented on each ostart pulse, wrapping 0xFFFF->0x0000.
REQ-030 SHALL, with GEMM_LOADER_FRAMECNT_EN undefined, have no oframe_count port and otherwise identical behaviour.

Structure
REQ-031 SHALL take the loader_state_t enum (LOAD_A, LOAD_B, LOAD_C, START, WAIT) and the default dimension constants from the shared package gemm_pkg.
REQ-032 SHALL implement the row/col walk in one sub-module, gemm_idx_counter, with inputs advance and clear and outputs row, col and last.

Verification
REQ-033 Reset then 48 back-to-back transfers, values 1..48 -> A=1..16, B=17..32 and C=33..48 row-major; ostart high only in the cycle after transfer 48.
REQ-034 Same frame with ivalid low on every other cycle -> identical matrices; ostart delayed accordingly; no element lost.
REQ-035 ivalid held high through START and WAIT -> oready=0 there and no matrix change; igemm_done pulse -> oready=1 on the next cycle, next element lands in A[0][0].
REQ-036 igemm_done pulsed in LOAD_B and coincident with START -> ignored, state still WAIT; second pulse in WAIT -> LOAD_A.
REQ-037 irst asserted after 20 transfers -> all matrices 0, state LOAD_A; a fresh 48-element frame loads correctly.
REQ-038 With GEMM_LOADER_FRAMECNT_EN, 3 full frames -> oframe_count=3; counter preset to 0xFFFF plus one frame -> 0x0000.
